// File: rtl/boot_pkg.sv
// Shared types and default widths for the boot sequencer.
package boot_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MAX_WORDS = 256;
    localparam int DEF_RST_HOLD  = 2;
    localparam int HOLD_CNT_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VRD,
        VCMP,
        HOLD,
        RUN,
        ERR
    } boot_state_e;

endpackage

// File: rtl/boot_hold_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module boot_hold_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mem_boot_ctrl.sv
// Boot sequencer: streams an image into memory, then releases the CPU after a reset hold.
// Optional readback verification of every beat is enabled with `define BOOT_VERIFY_EN.
module mem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS,
    parameter int RST_HOLD  = DEF_RST_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_go,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              test,
    output logic              cpu_rst_n,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_cnt
`ifdef BOOT_VERIFY_EN
    ,
    output logic [ADDR_W-1:0] err_addr
`endif
);

    boot_state_e       state_q, state_d;
    boot_state_e       exit_q, exit_d;     // state entered once the pending write cycle ends
    logic              wr_pend_q, wr_pend_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d, word_cnt_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              err_d;
    logic              hs, at_limit;
    logic              timer_load, timer_tc;

`ifdef BOOT_VERIFY_EN
    logic              beat_last_q, beat_last_d;
    logic              beat_ovf_q, beat_ovf_d;
    logic [ADDR_W-1:0] err_addr_d;
`else
    logic              unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    assign hs       = ld_valid & ld_ready;
    assign at_limit = (word_cnt == ADDR_W'(MAX_WORDS - 1));

    boot_hold_timer #(.W(HOLD_CNT_W)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (HOLD_CNT_W'(RST_HOLD - 1)),
        .en       (state_q == HOLD),
        .tc       (timer_tc)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        exit_d      = exit_q;
        wr_pend_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        word_cnt_d  = word_cnt;
        err_d       = err;
        timer_load  = 1'b0;
`ifdef BOOT_VERIFY_EN
        beat_last_d = beat_last_q;
        beat_ovf_d  = beat_ovf_q;
        err_addr_d  = err_addr;
`endif
        if (boot_go) begin
            // Abort wins over everything, including a beat offered this cycle.
            state_d    = LOAD;
            word_cnt_d = '0;
            err_d      = 1'b0;
`ifdef BOOT_VERIFY_EN
            err_addr_d = '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (wr_pend_q) begin
                        state_d    = exit_q;
                        timer_load = (exit_q == HOLD);
                        err_d      = (exit_q == ERR);
                    end else if (hs) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ld_addr;
                        mem_wdata_d = ld_data;
                        word_cnt_d  = word_cnt + 1'b1;
`ifdef BOOT_VERIFY_EN
                        exit_d      = VRD;
                        wr_pend_d   = 1'b1;
                        beat_last_d = ld_last;
                        beat_ovf_d  = !ld_last && at_limit;
`else
                        exit_d      = ld_last ? HOLD : (at_limit ? ERR : LOAD);
                        wr_pend_d   = ld_last || at_limit;
`endif
                    end
                end
                VRD:  state_d = VCMP;
                VCMP: begin
`ifdef BOOT_VERIFY_EN
                    if (mem_rdata != mem_wdata) begin
                        state_d    = ERR;
                        err_d      = 1'b1;
                        err_addr_d = mem_addr;
                    end else if (beat_last_q) begin
                        state_d    = HOLD;
                        timer_load = 1'b1;
                    end else if (beat_ovf_q) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = ERR;
                    err_d   = 1'b1;
`endif
                end
                HOLD: if (timer_tc) state_d = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            exit_q    <= IDLE;
            wr_pend_q <= 1'b0;
            ld_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            test      <= 1'b1;
            cpu_rst_n <= 1'b0;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            word_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            exit_q    <= exit_d;
            wr_pend_q <= wr_pend_d;
            ld_ready  <= (state_d == LOAD) && !wr_pend_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            test      <= !(state_d inside {HOLD, RUN});
            cpu_rst_n <= (state_d == RUN);
            cpu_start <= (state_d == RUN);
            busy      <= (state_d inside {LOAD, VRD, VCMP, HOLD});
            done      <= (state_d == RUN);
            err       <= err_d;
            word_cnt  <= word_cnt_d;
        end
    end

`ifdef BOOT_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_last_q <= 1'b0;
            beat_ovf_q  <= 1'b0;
            err_addr    <= '0;
        end else begin
            beat_last_q <= beat_last_d;
            beat_ovf_q  <= beat_ovf_d;
            err_addr    <= err_addr_d;
        end
    end
`endif

endmodule
